// File: rtl/control_sequencer_pkg.sv
// Shared opcode configuration for the control sequencer and its users.
// ALU ops are the odd opcodes, so every named opcode here is even.
package control_sequencer_pkg;

  localparam logic [3:0] OPCODE_LOAD  = 4'b0010;
  localparam logic [3:0] OPCODE_STORE = 4'b0100;
  localparam logic [3:0] OPCODE_SET   = 4'b0110;
  localparam logic [3:0] OPCODE_DUP   = 4'b1000;
  localparam logic [3:0] OPCODE_HCF   = 4'b1110;

endpackage

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: accepts one opcode at a time and steps
// through execute, memory and write-back phases, driving the datapath strobes.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                instr_ready,
  input  logic                mem_ready,
  output logic                alu_enable,
  output logic                use_imm,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_d_enable,
  output logic                pc_advance,
  output logic [2:0]          alu_func,
  output logic                halted,
  output logic                mem_fault,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_FAULT
  } state_t;

  state_t              state, state_nxt;
  logic [OPCODE_W-1:0] op_q;
  logic [7:0]          wait_cnt, wait_cnt_nxt;
  logic [CNT_W-1:0]    retired_q;

  logic is_alu, is_load, is_store, is_set, is_dup, is_hcf, writes_reg;

  assign is_alu     = op_q[0];
  assign is_load    = (op_q == OPCODE_W'(OPCODE_LOAD));
  assign is_store   = (op_q == OPCODE_W'(OPCODE_STORE));
  assign is_set     = (op_q == OPCODE_W'(OPCODE_SET));
  assign is_dup     = (op_q == OPCODE_W'(OPCODE_DUP));
  assign is_hcf     = (op_q == OPCODE_W'(OPCODE_HCF));
  assign writes_reg = is_alu | is_load | is_set | is_dup;

  assign alu_func = op_q[3:1];
  assign retired  = retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= '0;
      wait_cnt  <= '0;
      retired_q <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == S_IDLE && instr_valid)
        op_q <= opcode;
      if (pc_advance)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  // The wait counter only counts inside MEM; leaving MEM (or never entering it) clears it.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    instr_ready  = 1'b0;
    alu_enable   = 1'b0;
    use_imm      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_d_enable = 1'b0;
    pc_advance   = 1'b0;
    halted       = 1'b0;
    mem_fault    = 1'b0;

    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid)
          state_nxt = S_EXEC;
      end
      S_EXEC: begin
        alu_enable = is_alu;
        use_imm    = is_set;
        if (is_load || is_store)
          state_nxt = S_MEM;
        else if (is_hcf)
          state_nxt = S_HALT;
        else if (writes_reg)
          state_nxt = S_WB;
        else begin
          pc_advance = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      S_MEM: begin
        mem_read  = is_load;
        mem_write = is_store;
        if (mem_ready) begin
          if (is_load)
            state_nxt = S_WB;
          else begin
            pc_advance = 1'b1;
            state_nxt  = S_IDLE;
          end
        end else if (wait_cnt == 8'(MEM_TIMEOUT - 1))
          state_nxt = S_FAULT;
        else
          wait_cnt_nxt = wait_cnt + 8'd1;
      end
      S_WB: begin
        reg_d_enable = 1'b1;
        pc_advance   = 1'b1;
        use_imm      = is_set;
        state_nxt    = S_IDLE;
      end
      S_HALT:  halted    = 1'b1;
      S_FAULT: mem_fault = 1'b1;
      default: state_nxt = S_IDLE;
    endcase

    // While reset is held the datapath must see no activity, whatever the state.
    if (reset) begin
      instr_ready  = 1'b1;
      alu_enable   = 1'b0;
      use_imm      = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_d_enable = 1'b0;
      pc_advance   = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer: each instruction's
// expected per-cycle strobe pattern is built from its class and wait count.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  localparam int OW  = 4;
  localparam int TMO = 15;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          instr_valid = 1'b0;
  logic [OW-1:0] opcode = '0;
  logic          mem_ready = 1'b0;
  logic          instr_ready, alu_enable, use_imm, mem_read, mem_write;
  logic          reg_d_enable, pc_advance, halted, mem_fault;
  logic [2:0]    alu_func;
  logic [CW-1:0] retired;
  logic [8:0]    obs_vec;

  int n_checks = 0;
  int n_pass = 0;
  int exp_retired = 0;

  control_sequencer #(.OPCODE_W(OW), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(instr_ready), .mem_ready(mem_ready), .alu_enable(alu_enable),
    .use_imm(use_imm), .mem_read(mem_read), .mem_write(mem_write),
    .reg_d_enable(reg_d_enable), .pc_advance(pc_advance), .alu_func(alu_func),
    .halted(halted), .mem_fault(mem_fault), .retired(retired)
  );

  always #5 clk = ~clk;

  assign obs_vec = {instr_ready, alu_enable, use_imm, mem_read, mem_write,
                    reg_d_enable, pc_advance, halted, mem_fault};

  function automatic logic [8:0] vec(input logic ir, alu, imm, rd, wr, rde, pca, hlt, flt);
    return {ir, alu, imm, rd, wr, rde, pca, hlt, flt};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs just after the edge, sample on the falling edge.
  task automatic applyStimulus(input logic v, input logic [OW-1:0] op, input logic mr, input logic rst);
    @(posedge clk);
    #1;
    instr_valid = v;
    opcode      = op;
    mem_ready   = mr;
    reset       = rst;
    @(negedge clk);
  endtask

  // Runs one instruction from its accept cycle; stuck=1 if it ended in HALT or FAULT.
  task automatic runInstr(input logic [OW-1:0] op, input int waits, output logic stuck);
    logic alu_c, ld, st, st_set, hcf, wr_reg, rdy, done;
    alu_c  = op[0];
    ld     = (op == OPCODE_LOAD);
    st     = (op == OPCODE_STORE);
    st_set = (op == OPCODE_SET);
    hcf    = (op == OPCODE_HCF);
    wr_reg = alu_c | ld | st_set | (op == OPCODE_DUP);
    stuck  = 1'b0;
    done   = 1'b0;

    applyStimulus(1'b1, op, 1'($urandom), 1'b0);
    checkOutput("idle_vec", obs_vec, vec(1, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("idle_retired", retired, exp_retired);

    applyStimulus(1'($urandom), OW'($urandom), 1'($urandom), 1'b0);
    checkOutput("exec_vec", obs_vec,
                vec(0, alu_c, st_set, 0, 0, 0, !(ld | st | hcf | wr_reg), 0, 0));
    checkOutput("exec_alu_func", alu_func, op[3:1]);

    if (hcf) begin
      for (int i = 0; i < 3; i++) begin
        applyStimulus(1'($urandom), OW'($urandom), 1'($urandom), 1'b0);
        checkOutput("halt_vec", obs_vec, vec(0, 0, 0, 0, 0, 0, 0, 1, 0));
        checkOutput("halt_retired", retired, exp_retired);
      end
      stuck = 1'b1;
      return;
    end

    if (ld | st) begin
      for (int i = 0; i < TMO && !done; i++) begin
        rdy = (i == waits);
        applyStimulus(1'($urandom), OW'($urandom), rdy, 1'b0);
        checkOutput("mem_vec", obs_vec, vec(0, 0, 0, ld, st, 0, st & rdy, 0, 0));
        done = rdy;
      end
      if (!done) begin
        for (int i = 0; i < 3; i++) begin
          applyStimulus(1'($urandom), OW'($urandom), 1'($urandom), 1'b0);
          checkOutput("fault_vec", obs_vec, vec(0, 0, 0, 0, 0, 0, 0, 0, 1));
          checkOutput("fault_retired", retired, exp_retired);
        end
        stuck = 1'b1;
        return;
      end
    end

    if (wr_reg) begin
      applyStimulus(1'($urandom), OW'($urandom), 1'($urandom), 1'b0);
      checkOutput("wb_vec", obs_vec, vec(0, 0, st_set, 0, 0, 1, 1, 0, 0));
    end
    exp_retired = (exp_retired + 1) % (1 << CW);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("reset_strobes", obs_vec[8:2], 7'b1000000);
    exp_retired = 0;
  endtask

  initial begin
    logic stuck;
    logic [OW-1:0] op;
    int waits;

    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("reset_vec", obs_vec, vec(1, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("reset_retired", retired, 0);

    runInstr(4'b0011, 0, stuck);
    runInstr(OPCODE_LOAD, 3, stuck);
    runInstr(OPCODE_STORE, 0, stuck);
    runInstr(OPCODE_LOAD, TMO - 1, stuck);
    runInstr(OPCODE_SET, 0, stuck);
    runInstr(OPCODE_DUP, 0, stuck);
    runInstr(4'b1010, 0, stuck);

    runInstr(OPCODE_STORE, 1000, stuck);
    doReset();
    runInstr(OPCODE_HCF, 0, stuck);
    doReset();

    for (int i = 0; i < 17; i++) runInstr(4'b1100, 0, stuck);

    // Reset landing in the second MEM cycle of a LOAD
    applyStimulus(1'b1, OPCODE_LOAD, 1'b0, 1'b0);
    checkOutput("rstmem_idle_retired", retired, exp_retired);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("rstmem_mem1_read", mem_read, 1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("rstmem_mem2_read", mem_read, 0);
    checkOutput("rstmem_mem2_ready", instr_ready, 1);
    exp_retired = 0;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("rstmem_after_vec", obs_vec, vec(1, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("rstmem_after_retired", retired, 0);

    for (int i = 0; i < 60; i++) begin
      op = OW'($urandom);
      waits = ($urandom_range(0, 9) == 0) ? TMO + 3 : int'($urandom_range(0, 4));
      runInstr(op, waits, stuck);
      if (stuck) doReset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
